// File: rtl/clk_divider_1hz.sv
// Free-running divider: clk_1Hz is a registered 50% square wave with period 2*DIV clk_100MHz cycles.
// Optional feature macro CLK_DIV_ENABLE_EN adds an enable input that freezes count and output.
module clk_divider_1hz #(
    parameter int DIV = 50_000_000
) (
    input  logic clk_100MHz,
    input  logic rst,
`ifdef CLK_DIV_ENABLE_EN
    input  logic enable,
`endif
    output logic clk_1Hz
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    // Terminal value sized to the counter so the compare never relies on wrap at 2^CW.
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;
    logic          run;
    logic          terminal;

`ifdef CLK_DIV_ENABLE_EN
    assign run = enable;
`else
    assign run = 1'b1;
`endif

    assign terminal = (count == LAST);

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            count   <= '0;
            clk_1Hz <= 1'b0;
        end else if (run) begin
            if (terminal) begin
                count   <= '0;
                clk_1Hz <= ~clk_1Hz;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_divider_1hz.sv
// Bench for clk_divider_1hz: DIV=5, DIV=1 and DIV=1024 instances checked against an
// edge-counting reference model (output = floor(enabled_edges_since_reset / DIV) mod 2).
module tb_clk_divider_1hz;

    logic clk;
    logic rst;
    logic enable;
    logic clk5;
    logic clk1;
    logic clkb;

    int checks;
    int failures;
    int edges;
    int n5;
    int n1;
    int nb;
    logic [31:0] exp_q[$];

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    clk_divider_1hz #(.DIV(5)) dut (
        .clk_100MHz(clk),
        .rst(rst),
`ifdef CLK_DIV_ENABLE_EN
        .enable(enable),
`endif
        .clk_1Hz(clk5)
    );

    clk_divider_1hz #(.DIV(1)) dut_div1 (
        .clk_100MHz(clk),
        .rst(rst),
`ifdef CLK_DIV_ENABLE_EN
        .enable(enable),
`endif
        .clk_1Hz(clk1)
    );

    clk_divider_1hz #(.DIV(1024)) dut_big (
        .clk_100MHz(clk),
        .rst(rst),
`ifdef CLK_DIV_ENABLE_EN
        .enable(enable),
`endif
        .clk_1Hz(clkb)
    );

    // Reference model: count enabled edges since the last reset edge.
    logic model_en;
`ifdef CLK_DIV_ENABLE_EN
    assign model_en = enable;
`else
    assign model_en = 1'b1;
`endif

    always @(posedge clk) begin
        if (rst) begin
            n5 <= 0;
            n1 <= 0;
            nb <= 0;
        end else if (model_en) begin
            n5 <= n5 + 1;
            n1 <= n1 + 1;
            nb <= nb + 1;
        end
    end

    function automatic logic model_out(input int n, input int div);
        return ((n / div) % 2) == 1;
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (clk5 !== 1'b0 || clk1 !== 1'b0 || clkb !== 1'b0) begin
                failures++;
                $display("FAIL reset cyc=%0d got div5=%b div1=%b div1024=%b want 0 0 0", i, clk5, clk1, clkb);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_toggle_timing;
        logic prev;
        int total;
        do_reset(2);
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(32'd5);
        total = 0;
        prev = clk5;
        for (int t = 0; t < 10; t++) begin
            edges = 0;
            while (clk5 === prev && edges < 20) begin
                tick();
                edges++;
            end
            prev = clk5;
            total += edges;
            checks++;
            if (edges !== exp_q.pop_front()) begin
                failures++;
                $display("FAIL toggle_interval idx=%0d got %0d edges want 5", t, edges);
            end
        end
        checks++;
        if (total !== 50 || clk5 !== 1'b0) begin
            failures++;
            $display("FAIL ten_toggles got total=%0d out=%b want 50 0", total, clk5);
        end
    endtask

    task automatic test_mid_reset;
        do_reset(1);
        repeat (8) tick();
        checks++;
        if (clk5 !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_pre got %b want 1", clk5);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (clk5 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_clear got %b want 0", clk5);
        end
        edges = 0;
        while (clk5 !== 1'b1 && edges < 20) begin
            tick();
            edges++;
        end
        checks++;
        if (edges !== 5) begin
            failures++;
            $display("FAIL mid_reset_rise got %0d edges want 5", edges);
        end
    endtask

    task automatic test_div1;
        do_reset(1);
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (clk1 !== logic'(i % 2)) begin
                failures++;
                $display("FAIL div1 edge=%0d got %b want %b", i, clk1, logic'(i % 2));
            end
        end
    endtask

    task automatic test_big;
        do_reset(1);
        edges = 0;
        while (clkb !== 1'b1 && edges < 1100) begin
            tick();
            edges++;
        end
        checks++;
        if (edges !== 1024) begin
            failures++;
            $display("FAIL big_first_rise got %0d edges want 1024", edges);
        end
        edges = 0;
        while (clkb !== 1'b0 && edges < 1100) begin
            tick();
            edges++;
        end
        checks++;
        if (edges !== 1024) begin
            failures++;
            $display("FAIL big_high_time got %0d edges want 1024", edges);
        end
    endtask

`ifdef CLK_DIV_ENABLE_EN
    task automatic test_enable;
        enable = 1'b1;
        do_reset(1);
        repeat (7) tick();
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        edges = 10;
        while (clk5 !== 1'b0 && edges < 30) begin
            tick();
            edges++;
        end
        checks++;
        if (edges !== 13) begin
            failures++;
            $display("FAIL enable_gap fall at %0d edges want 13", edges);
        end
        while (clk5 !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        checks++;
        if (edges !== 18) begin
            failures++;
            $display("FAIL enable_next_rise at %0d edges want 18", edges);
        end
        enable = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (clk5 !== 1'b0 || clkb !== 1'b0) begin
            failures++;
            $display("FAIL reset_while_disabled got %b %b want 0 0", clk5, clkb);
        end
        enable = 1'b1;
    endtask
`endif

    task automatic test_random;
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 699) == 0);
`ifdef CLK_DIV_ENABLE_EN
            enable = ($urandom_range(0, 3) != 0);
`endif
            tick();
            checks++;
            if (clk5 !== model_out(n5, 5) || clk1 !== model_out(n1, 1) || clkb !== model_out(nb, 1024)) begin
                failures++;
                $display("FAIL random cyc=%0d got %b %b %b want %b %b %b", i, clk5, clk1, clkb,
                         model_out(n5, 5), model_out(n1, 1), model_out(nb, 1024));
            end
        end
        rst = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        test_reset();
        test_toggle_timing();
        test_mid_reset();
        test_div1();
        test_big();
`ifdef CLK_DIV_ENABLE_EN
        test_enable();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
